// File: rtl/invsqrt_pkg.sv
// Shared constants, FSM encoding and helpers for the inverse-square-root arbiter.
// Optional issue counters are enabled with INVSQRT_ARB_CNT_EN.
package invsqrt_pkg;

  localparam int FP_W     = 32;
  localparam int FP_OUT_W = 31;
  localparam int PIPE_LAT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/invsqrt_rr_arb.sv
// Round-robin picker: the search starts at a registered pointer, and the pointer
// moves past the winner whenever an advance cycle produces a grant.
module invsqrt_rr_arb
  import invsqrt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] pick;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    hi = '0;
    for (int j = 0; j < NREQ; j++)
      hi[j] = req[j] && (j >= int'(ptr));
    pick   = (|hi) ? hi : req;
    gnt    = '0;
    gnt_id = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (pick[j] && advance) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        gnt_id = IDW'(j);
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)
      ptr <= '0;
    else if (advance && |req)
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

endmodule

// File: rtl/invsqrt_arbiter.sv
// Shares one inverse-sqrt pipeline between NREQ requesters, tags in-flight operands
// and routes results home. Define INVSQRT_ARB_CNT_EN for per-requester issue counters.
module invsqrt_arbiter
  import invsqrt_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int PIPE_LAT = invsqrt_pkg::PIPE_LAT,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 pipe_valid,
  output logic [FP_W-1:0]      pipe_float_in,
  input  logic                 pipe_ready,
  input  logic [FP_OUT_W-1:0]  pipe_float_out,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [FP_OUT_W-1:0]  rsp_data,
  output logic                 busy,
  output logic                 err
`ifdef INVSQRT_ARB_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [NREQ*16-1:0]   cnt_issue
`endif
);

  localparam int BLK_W = clog2(PIPE_LAT + 1);

  state_t                           state, state_nxt;
  logic [BLK_W-1:0]                 blank_cnt;
  logic                             blanking;
  logic                             run_en;
  logic                             inflight;
  logic [NREQ-1:0]                  sel;
  logic [IDW-1:0]                   sel_id;
  logic [IDW-1:0]                   issue_id;
  logic [NREQ-1:0][FP_W-1:0]        ops;
  logic [FP_W-1:0]                  op_sel;
  logic [PIPE_LAT-1:0]              tag_v;
  logic [PIPE_LAT-1:0][IDW-1:0]     tag_id;
  logic [NREQ-1:0]                  rsp_hot;
  logic                             hit, miss;

  assign ops      = req_data;
  assign blanking = |blank_cnt;
  assign inflight = pipe_valid | (|tag_v);

  // ---- FSM ----
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en && !blanking) state_nxt = ST_RUN;
      ST_RUN:   if (!en)             state_nxt = ST_DRAIN;
      ST_DRAIN: if (en)              state_nxt = ST_RUN;
                else if (!inflight)  state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en = (state == ST_RUN) && en;
    busy   = (state != ST_IDLE) || inflight;
  end

  // The pipeline is not reset, so its output is ignored until anything it held has drained.
  always_ff @(posedge clk or posedge rst)
    if (rst)           blank_cnt <= BLK_W'(PIPE_LAT);
    else if (blanking) blank_cnt <= blank_cnt - 1'b1;

  // ---- issue ----
  invsqrt_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .advance (run_en),
    .req     (req),
    .gnt     (sel),
    .gnt_id  (sel_id)
  );

  always_comb begin
    op_sel = '0;
    for (int j = 0; j < NREQ; j++)
      if (sel[j]) op_sel = ops[j];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt           <= '0;
      pipe_valid    <= 1'b0;
      pipe_float_in <= '0;
      issue_id      <= '0;
    end else begin
      gnt        <= sel;
      pipe_valid <= |sel;
      issue_id   <= sel_id;
      if (|sel) pipe_float_in <= op_sel;
    end

  // Tag line samples pipe_valid, so its last entry lines up with pipe_ready.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= pipe_valid;
      tag_id[0] <= issue_id;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end

  // ---- return ----
  assign hit  = !blanking && pipe_ready && tag_v[PIPE_LAT-1];
  assign miss = !blanking && (pipe_ready != tag_v[PIPE_LAT-1]);

  always_comb begin
    rsp_hot = '0;
    for (int j = 0; j < NREQ; j++)
      rsp_hot[j] = (tag_id[PIPE_LAT-1] == IDW'(j));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= hit ? rsp_hot : '0;
      if (hit) begin
        rsp_id   <= tag_id[PIPE_LAT-1];
        rsp_data <= pipe_float_out;
      end
      if (miss) err <= 1'b1;
    end

`ifdef INVSQRT_ARB_CNT_EN
  logic [NREQ-1:0][15:0] cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)
      cnt <= '0;
    else
      for (int j = 0; j < NREQ; j++)
        if (cnt_clr)                     cnt[j] <= '0;
        else if (sel[j] && cnt[j] != '1) cnt[j] <= cnt[j] + 1'b1;

  assign cnt_issue = cnt;
`endif

endmodule

// File: doc/invsqrt_arbiter.md
Name: invsqrt_arbiter

Overview:
- Shares one `invsqrt_pipeline` instance between NREQ requesters.
- Grants one request per cycle by round-robin and drives the pipeline's `valid`/`float_in`.
- Tracks the requester ID of each in-flight operand in a tag shift register matched to the pipeline latency.
- Routes each `ready`/`float_out` result back to its originating requester. Includes enable/drain sequencing and a sticky tag-mismatch error.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PIPE_LAT, 5, cycles from pipeline `valid` to `ready`; must equal the pipeline stage count.
- IDW, 2, requester ID width, ≥ clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  arbitration enable; low stops new grants.
- req  in  NREQ  per-requester request, level, held until granted.
- req_data  in  NREQ*32  packed IEEE-754 single operands; slice i belongs to requester i.
- gnt  out  NREQ  one-hot grant pulse; operand sampled this cycle.
- pipe_valid  out  1  to pipeline `valid`.
- pipe_float_in  out  32  to pipeline `float_in`.
- pipe_ready  in  1  from pipeline `ready`.
- pipe_float_out  in  31  from pipeline `float_out` (sign-free result).
- rsp_valid  out  NREQ  one-hot result strobe, 1 cycle.
- rsp_id  out  IDW  requester ID of current result.
- rsp_data  out  31  result, shared bus.
- busy  out  1  high while any operand is in flight or state ≠ IDLE.
- err  out  1  sticky: pipe_ready with no matching tag, or tag with no pipe_ready.

Behaviour:
- Reset: all outputs 0, state IDLE, tag register cleared, RR pointer = 0, blank counter = PIPE_LAT.
- Blanking: the pipeline has no reset, so stale results can emerge after reset. While the blank counter is nonzero, it decrements each cycle, pipe_ready is ignored, no error is raised, and no grants are issued.
- States:
  - IDLE → RUN when en=1 and blank counter = 0.
  - RUN → DRAIN when en=0.
  - DRAIN → IDLE when the tag register is empty.
  - DRAIN → RUN when en=1 again.
- Grants are issued only in RUN.
- Arbitration (RUN): search starts at RR pointer. The first i with req[i]=1 is granted. Pointer advances to i+1 mod NREQ; it is unchanged if there is no grant.
- Issue timing, for a grant combinationally selected in cycle T:
  - gnt[i] is a registered output, high in cycle T+1.
  - pipe_valid=1 and pipe_float_in=req_data[i] are registered together with gnt, also in T+1.
  - Requester deasserts req[i] after seeing gnt[i]. req still high in T+1 is treated as a new request, but the pointer rotation prevents back-to-back grants to one requester when others are waiting.
- Throughput: at most one issue per cycle, no bubbles.
- Tag register: PIPE_LAT entries of {v, id}.
  - Entry 0 loads {pipe_valid, granted id} alongside pipe_valid, then the register shifts every cycle.
  - The last entry aligns with pipe_ready.
- Return: when pipe_ready=1 and the last entry has v=1, the block registers rsp_valid[id]=1, rsp_id=id and rsp_data=pipe_float_out. Result latency is pipeline latency + 1 cycle.
- Mismatch: pipe_ready differs from the last entry's v (outside blanking) → err=1 until rst. The result is dropped.
- Simultaneous issue and return in one cycle are fully supported.
- rst asserted mid-operation: in-flight results are discarded via blanking; no rsp_valid fires for them.
- NREQ=1 degenerates to a pass-through with tagging.

Optional Feature:
- Macro: INVSQRT_ARB_CNT_EN.
- When defined, adds ports cnt_clr (in, 1) and cnt_issue (out, NREQ*16).
  - Per-requester 16-bit saturating count of issued operands.
  - Cleared by rst or cnt_clr; cnt_clr wins over a simultaneous increment.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package invsqrt_pkg:
  - FP_W=32, FP_OUT_W=31, PIPE_LAT=5.
  - State encoding IDLE/RUN/DRAIN.
  - Function for clog2.
- One sub-module, invsqrt_rr_arb: NREQ-wide round-robin picker with a registered pointer, an advance input, and a one-hot grant out.

Test Plan:
- Single requester 0, en=1, req_data[0]=0x40800000 (4.0) → gnt[0] 1 cycle after req. rsp_valid[0] and rsp_id=0 arrive PIPE_LAT+1 cycles after gnt. rsp_data≈0x3F000000 (0.5), within 0.2% relative.
- All 4 req held continuously with operands 1.0, 4.0, 16.0, 0.25 → grants 0,1,2,3,0,... on consecutive cycles. Each rsp_id matches its issue order. Results are ≈1.0, 0.5, 0.25, 2.0 (0x3F800000, 0x3F000000, 0x3E800000, 0x40000000).
- en dropped after 3 issues → no further gnt; busy stays high until the 3rd rsp_valid, then returns to IDLE with busy=0.
- Assert rst 2 cycles after an issue, then release → no rsp_valid for the pre-reset operand, err=0, first grant only after PIPE_LAT blanking cycles.
- Force pipe_ready=1 with an empty tag register (outside blanking) → err=1 next cycle and sticky; no rsp_valid.
- With INVSQRT_ARB_CNT_EN: 10 issues to requester 2 → cnt_issue[2]=10. cnt_clr coinciding with an issue → counter reads 0.
